// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : Pipeline MEM stage. Runs data-memory loads/stores over a
//             req/ack bus, stalls stages 1-4 until the access completes or
//             times out, and loads the stage-5 pipeline register.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] IR4,
    input  logic [DW-1:0] PC4,
    input  logic [DW-1:0] Z4,
    input  logic [DW-1:0] S4,
    input  logic          MemToReg4,
    input  logic          MemWrite4,
    input  logic          MemRead4,
    input  logic          RegWrite4,
    input  logic          JAL4,
    input  logic [4:0]    WA_4,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          stall_mem,
    output logic          mem_err,
    output logic [DW-1:0] Z5,
    output logic [DW-1:0] IR5,
    output logic [DW-1:0] PC5,
    output logic [4:0]    WA_5,
    output logic          RegWrite5,
    output logic          MemToReg5,
    output logic          JAL5
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int             c_cnt_w    = 8;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]        lmd_q, lmd_d;
    logic                 err_q, err_d;
    logic                 abort_q, abort_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [DW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;

    logic [DW-1:0]        z5_q, z5_d;
    logic [DW-1:0]        ir5_q, ir5_d;
    logic [DW-1:0]        pc5_q, pc5_d;
    logic [4:0]           wa5_q, wa5_d;
    logic                 rw5_q, rw5_d;
    logic                 m2r5_q, m2r5_d;
    logic                 jal5_q, jal5_d;

    logic w_mem_op;
    logic w_load;
    logic w_stall;

    // A write wins when both read and write are flagged.
    assign w_mem_op = MemRead4 | MemWrite4;
    assign w_load   = MemRead4 & ~MemWrite4;
    assign w_stall  = ((state_q == S_IDLE) & w_mem_op) | (state_q == S_REQ);

    // Access FSM: next state, timeout counter, LMD capture and bus drive.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lmd_d   = lmd_q;
        err_d   = err_q;
        abort_d = abort_q;
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                if (w_mem_op) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = MemWrite4;
                    addr_d  = Z4;
                    wdata_d = S4;
                end
            end
            S_REQ: begin
                if (dmem_ack) begin
                    lmd_d   = dmem_rdata;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (cnt_q == c_cnt_last) begin
                    // Give up: flag the error and retire with a zero LMD.
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    lmd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    req_d   = 1'b1;
                    we_d    = MemWrite4;
                    addr_d  = Z4;
                    wdata_d = S4;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stage-5 register input: bubble while stalled, otherwise retire stage 4.
    always_comb begin
        z5_d   = z5_q;
        pc5_d  = pc5_q;
        ir5_d  = '0;
        wa5_d  = '0;
        rw5_d  = 1'b0;
        m2r5_d = 1'b0;
        jal5_d = 1'b0;
        if (!w_stall) begin
            ir5_d  = IR4;
            pc5_d  = PC4;
            wa5_d  = WA_4;
            m2r5_d = MemToReg4;
            jal5_d = JAL4;
            rw5_d  = RegWrite4 & ~(abort_q & w_load);
            z5_d   = (w_load & MemToReg4) ? lmd_q : Z4;
        end
    end

    // State and pipeline register, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lmd_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            z5_q    <= '0;
            ir5_q   <= '0;
            pc5_q   <= '0;
            wa5_q   <= '0;
            rw5_q   <= 1'b0;
            m2r5_q  <= 1'b0;
            jal5_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lmd_q   <= lmd_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            z5_q    <= z5_d;
            ir5_q   <= ir5_d;
            pc5_q   <= pc5_d;
            wa5_q   <= wa5_d;
            rw5_q   <= rw5_d;
            m2r5_q  <= m2r5_d;
            jal5_q  <= jal5_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign stall_mem  = w_stall;
    assign mem_err    = err_q;
    assign Z5         = z5_q;
    assign IR5        = ir5_q;
    assign PC5        = pc5_q;
    assign WA_5       = wa5_q;
    assign RegWrite5  = rw5_q;
    assign MemToReg5  = m2r5_q;
    assign JAL5       = jal5_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Self-checking bench for mem_access_stage (scoreboard of
//             expected stage-5 retirements).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_stage;

    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] IR4, PC4, Z4, S4;
    logic          MemToReg4, MemWrite4, MemRead4, RegWrite4, JAL4;
    logic [4:0]    WA_4;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic          stall_mem, mem_err;
    logic [DW-1:0] Z5, IR5, PC5;
    logic [4:0]    WA_5;
    logic          RegWrite5, MemToReg5, JAL5;

    int n_run  = 0;
    int n_fail = 0;
    bit exp_err = 1'b0;

    typedef struct packed {
        logic [DW-1:0] z;
        logic [DW-1:0] ir;
        logic [DW-1:0] pc;
        logic [4:0]    wa;
        logic          rw;
        logic          m2r;
        logic          jal;
    } exp_t;

    exp_t sb[$];

    mem_access_stage #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .IR4(IR4), .PC4(PC4), .Z4(Z4), .S4(S4),
        .MemToReg4(MemToReg4), .MemWrite4(MemWrite4), .MemRead4(MemRead4),
        .RegWrite4(RegWrite4), .JAL4(JAL4), .WA_4(WA_4),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .mem_err(mem_err),
        .Z5(Z5), .IR5(IR5), .PC5(PC5), .WA_5(WA_5),
        .RegWrite5(RegWrite5), .MemToReg5(MemToReg5), .JAL5(JAL5)
    );

    always #5 clk = ~clk;

    task automatic set_instr(input logic [31:0] ir, input logic [31:0] pc,
                             input logic [31:0] z, input logic [31:0] s,
                             input logic mr, input logic mw, input logic m2r,
                             input logic rw, input logic jal, input logic [4:0] wa);
        IR4 = ir; PC4 = pc; Z4 = z; S4 = s;
        MemRead4 = mr; MemWrite4 = mw; MemToReg4 = m2r;
        RegWrite4 = rw; JAL4 = jal; WA_4 = wa;
    endtask

    task automatic set_nop();
        set_instr('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    // Issue one instruction; ack_wait = REQ cycles without ack before the ack
    // (negative: never ack). Checks bus, stalls, bubbles and the retirement.
    task automatic run_instr(input string name,
                             input logic [31:0] ir, input logic [31:0] pc,
                             input logic [31:0] z, input logic [31:0] s,
                             input logic mr, input logic mw, input logic m2r,
                             input logic rw, input logic jal, input logic [4:0] wa,
                             input int ack_wait, input logic [31:0] rdata);
        exp_t e, got;
        int   stalls, reqs, exp_stalls, exp_reqs;
        bit   done, is_mem, is_load, st, rq;
        is_mem  = mr | mw;
        is_load = mr & ~mw;
        e.z   = (is_load & m2r) ? ((ack_wait < 0) ? 32'h0 : rdata) : z;
        e.ir  = ir;
        e.pc  = pc;
        e.wa  = wa;
        e.rw  = rw & ~(is_load & (ack_wait < 0));
        e.m2r = m2r;
        e.jal = jal;
        sb.push_back(e);
        if (is_mem && ack_wait < 0) exp_err = 1'b1;
        exp_stalls = !is_mem ? 0 : ((ack_wait < 0) ? TIMEOUT + 1 : ack_wait + 2);
        exp_reqs   = !is_mem ? 0 : ((ack_wait < 0) ? TIMEOUT : ack_wait + 1);
        set_instr(ir, pc, z, s, mr, mw, m2r, rw, jal, wa);
        dmem_rdata = ~rdata;
        stalls = 0; reqs = 0; done = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            st = stall_mem;
            rq = dmem_req;
            if (rq) begin
                reqs++;
                n_run++;
                if ({dmem_we, dmem_addr, dmem_wdata} !== {mw, z, s}) begin
                    n_fail++;
                    $display("FAIL %s bus: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                             name, dmem_we, dmem_addr, dmem_wdata, mw, z, s);
                end
                if (ack_wait >= 0 && reqs - 1 == ack_wait) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            if (st) stalls++;
            @(posedge clk);
            #1;
            dmem_ack   = 1'b0;
            dmem_rdata = ~rdata;
            if (st) begin
                n_run++;
                if ({IR5, RegWrite5, WA_5} !== '0) begin
                    n_fail++;
                    $display("FAIL %s bubble: got IR5=%h RegWrite5=%0b WA_5=%0d, want zeros",
                             name, IR5, RegWrite5, WA_5);
                end
            end else begin
                done = 1'b1;
                e = sb.pop_front();
                got = {Z5, IR5, PC5, WA_5, RegWrite5, MemToReg5, JAL5};
                n_run++;
                if (Z5 !== e.z) begin
                    n_fail++;
                    $display("FAIL %s Z5: got %h, want %h", name, Z5, e.z);
                end
                n_run++;
                if (RegWrite5 !== e.rw) begin
                    n_fail++;
                    $display("FAIL %s RegWrite5: got %0b, want %0b", name, RegWrite5, e.rw);
                end
                n_run++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s stage5: got %h, want %h", name, got, e);
                end
            end
        end
        if (!done) begin
            n_run++;
            n_fail++;
            $display("FAIL %s retire: got no retirement in 64 cycles, want one", name);
        end
        n_run++;
        if (stalls != exp_stalls) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d, want %0d", name, stalls, exp_stalls);
        end
        n_run++;
        if (reqs != exp_reqs) begin
            n_fail++;
            $display("FAIL %s req_cycles: got %0d, want %0d", name, reqs, exp_reqs);
        end
        n_run++;
        if (mem_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s mem_err: got %0b, want %0b", name, mem_err, exp_err);
        end
        set_nop();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        set_nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_run++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err, stall_mem} !== '0) begin
            n_fail++;
            $display("FAIL reset bus: got req=%0b we=%0b addr=%h wdata=%h err=%0b stall=%0b, want zeros",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err, stall_mem);
        end
        n_run++;
        if ({Z5, IR5, PC5, WA_5, RegWrite5, MemToReg5, JAL5} !== '0) begin
            n_fail++;
            $display("FAIL reset stage5: got Z5=%h IR5=%h PC5=%h WA_5=%0d, want zeros", Z5, IR5, PC5, WA_5);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        run_instr("alu", 32'h0022_8293, 32'h0000_0010, 32'h0000_0011, 32'h0,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 0, 32'h0);
    endtask

    task automatic test_load();
        run_instr("load", 32'h1000_2003, 32'h0000_0014, 32'h0000_0100, 32'h0,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 0, 32'hDEAD_BEEF);
    endtask

    task automatic test_store();
        run_instr("store", 32'h0040_2023, 32'h0000_0018, 32'h0000_0040, 32'h0000_1234,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3, 32'h0);
    endtask

    task automatic test_read_write_both();
        run_instr("rw_both", 32'h0000_00A3, 32'h0000_001C, 32'h0000_0080, 32'h0000_5555,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1, 32'h0BAD_0BAD);
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_a", 32'h0000_3003, 32'h0000_0020, 32'h0000_0200, 32'h0,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd11, 1, 32'h1111_2222);
        run_instr("b2b_b", 32'h0000_3023, 32'h0000_0024, 32'h0000_0204, 32'hCAFE_0001,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 0, 32'h0);
        run_instr("b2b_c", 32'h0000_3083, 32'h0000_0028, 32'h0000_0208, 32'h0,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 2, 32'h3333_4444);
    endtask

    task automatic test_spurious_ack();
        set_instr(32'h0000_0333, 32'h0000_0030, 32'h0000_0077, 32'h0,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        n_run++;
        if ({Z5, RegWrite5, stall_mem, dmem_req} !== {32'h77, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL spurious_alu: got Z5=%h rw=%0b stall=%0b req=%0b, want 00000077 1 0 0",
                     Z5, RegWrite5, stall_mem, dmem_req);
        end
        run_instr("spurious_load", 32'h0000_4003, 32'h0000_0034, 32'h0000_0300, 32'h0,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 0, 32'h0000_0005);
    endtask

    task automatic test_timeout();
        run_instr("timeout_load", 32'h0000_5003, 32'h0000_0040, 32'h0000_0400, 32'h0,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, -1, 32'h0);
        run_instr("after_timeout", 32'h0000_5033, 32'h0000_0044, 32'h0000_0099, 32'h0,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 0, 32'h0);
    endtask

    task automatic test_reset_mid_req();
        int reqs;
        set_instr(32'h0000_6003, 32'h0000_0300, 32'h0000_0200, 32'h0,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9);
        dmem_ack = 1'b0;
        reqs = 0;
        for (int c = 0; c < 16 && reqs < 2; c++) begin
            @(negedge clk);
            if (dmem_req) reqs++;
        end
        n_run++;
        if (reqs < 2) begin
            n_fail++;
            $display("FAIL rst_mid_req reach: got %0d REQ cycles, want 2", reqs);
        end
        #1 rst = 1'b1;
        #1;
        exp_err = 1'b0;
        n_run++;
        if ({dmem_req, mem_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_req bus: got req=%0b err=%0b, want 0 0", dmem_req, mem_err);
        end
        n_run++;
        if ({Z5, IR5, PC5, WA_5, RegWrite5, MemToReg5, JAL5} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_req stage5: got Z5=%h IR5=%h PC5=%h WA_5=%0d rw=%0b, want zeros",
                     Z5, IR5, PC5, WA_5, RegWrite5);
        end
        set_nop();
        #1;
        n_run++;
        if (stall_mem !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_req idle: got stall_mem=%0b, want 0", stall_mem);
        end
        rst = 1'b0;
        run_instr("after_reset", 32'h0000_7033, 32'h0000_0304, 32'h0000_00AB, 32'h0,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_read_write_both();
        test_back_to_back();
        test_spurious_ack();
        test_timeout();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
